// File: rtl/quadrature_gen.sv
// Quadrature A/B generator: walks a Gray-coded two-phase output toward a loaded
// target position, one edge per programmable interval, shortest path with wrap.
module quadrature_gen #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     target,
    input  logic [DIV_WIDTH-1:0] period,
    input  logic                 load,
    output logic                 a,
    output logic                 b,
    output logic [WIDTH-1:0]     position,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [1:0]           p_q, p_d;
    logic                 half_q, half_d;
    logic                 dir_q, dir_d;
    logic [WIDTH-1:0]     pos_d;
    logic [WIDTH-1:0]     tgt_q, tgt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] interval_m1;
    logic                 done_d;
    logic                 a_d, b_d;
    logic [WIDTH-1:0]     diff;
    logic                 step_up;
    logic                 tick;

    assign diff        = tgt_q - position;
    // A half-finished step always completes in the direction it started.
    assign step_up     = half_q ? dir_q : ~diff[WIDTH-1];
    assign interval_m1 = (period == '0) ? '0 : period - DIV_WIDTH'(1);
    // >= rather than == so a shortened period takes effect at the next compare.
    assign tick        = (div_q >= interval_m1);
    assign busy        = (state_q == RUN);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        p_d     = p_q;
        half_d  = half_q;
        dir_d   = dir_q;
        pos_d   = position;
        tgt_d   = load ? target : tgt_q;
        div_d   = div_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                div_d = '0;
                if (diff != '0 && !half_q) state_d = RUN;
            end
            RUN: begin
                if (!half_q && diff == '0) begin
                    // Retargeted onto the current position at a step boundary.
                    state_d = IDLE;
                    div_d   = '0;
                    done_d  = 1'b1;
                end else if (tick) begin
                    div_d  = '0;
                    dir_d  = step_up;
                    p_d    = step_up ? p_q + 2'd1 : p_q - 2'd1;
                    half_d = ~half_q;
                    if (half_q) begin
                        pos_d = step_up ? position + WIDTH'(1) : position - WIDTH'(1);
                        if (pos_d == tgt_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        a_d = (p_d == 2'd1) || (p_d == 2'd2);
        b_d = p_d[1];
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            p_q      <= 2'd0;
            half_q   <= 1'b0;
            dir_q    <= 1'b0;
            position <= '0;
            tgt_q    <= '0;
            div_q    <= '0;
            done     <= 1'b0;
            a        <= 1'b0;
            b        <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            half_q   <= half_d;
            dir_q    <= dir_d;
            position <= pos_d;
            tgt_q    <= tgt_d;
            div_q    <= div_d;
            done     <= done_d;
            a        <= a_d;
            b        <= b_d;
        end
    end

endmodule

// File: tb/tb_quadrature_gen.sv
// Bench for quadrature_gen: timeline model of each move plus a far-end
// quadrature decoder, with randomized targets and periods.
module tb_quadrature_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  target;
    logic [15:0] period;
    logic        load;
    logic        a, b;
    logic [7:0]  position;
    logic        busy, done;

    int n_checks = 0;
    int n_pass   = 0;
    int m_pos    = 0;
    int m_phase  = 0;

    logic [1:0] prev_ab;
    int         edge_cnt;
    int         dbl_cnt;
    int         done_cnt;
    logic [7:0] enc_cnt;

    quadrature_gen #(.WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk(clk), .reset(rst_n), .target(target), .period(period), .load(load),
        .a(a), .b(b), .position(position), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Far-end encoder counter and edge monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ab  <= 2'b00;
            edge_cnt <= 0;
            dbl_cnt  <= 0;
            done_cnt <= 0;
            enc_cnt  <= 8'd0;
        end else begin
            prev_ab <= {a, b};
            if ({a, b} != prev_ab) edge_cnt <= edge_cnt + 1;
            if ((prev_ab ^ {a, b}) == 2'b11) dbl_cnt <= dbl_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            case ({prev_ab, a, b})
                4'b0010, 4'b1101: enc_cnt <= enc_cnt + 8'd1;
                4'b0001, 4'b1110: enc_cnt <= enc_cnt - 8'd1;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [1:0] ab_of(input int ph);
        case (ph & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_state", {a, b, position, busy, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_pos   = 0;
        m_phase = 0;
    endtask

    task automatic wait_edges(input int n, input string tag);
        int c = 0;
        while (edge_cnt < n && c < 2000) begin
            @(negedge clk);
            #1;
            c++;
        end
        check(tag, edge_cnt, n);
    endtask

    // Loads tgt from idle and checks every cycle against the move's timeline:
    // edge m lands I*m clocks after busy rises, each pair of edges is one step.
    task automatic run_move(input int tgt, input int per);
        int ii, diff, n, sgn, len, e;
        logic [7:0] exp_pos;
        logic [1:0] exp_ab;
        logic       exp_busy, exp_done;
        ii   = (per == 0) ? 1 : per;
        diff = (tgt - m_pos) & 255;
        if (diff == 0)      begin n = 0;          sgn = 0;  end
        else if (diff < 128) begin n = diff;       sgn = 1;  end
        else                begin n = 256 - diff; sgn = -1; end
        len = 2 * n * ii;
        @(posedge clk);
        #1;
        target = tgt[7:0];
        period = per[15:0];
        load   = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        for (int j = 0; j <= len + 3; j++) begin
            @(negedge clk);
            e = (j >= 1) ? (j - 1) / ii : 0;
            if (e > 2 * n) e = 2 * n;
            exp_pos  = 8'((m_pos + sgn * (e / 2)) & 255);
            exp_ab   = ab_of(m_phase + sgn * e);
            exp_busy = (n > 0) && (j >= 1) && (j < 1 + len);
            exp_done = (n > 0) && (j == 1 + len);
            check($sformatf("t%02h_p%0d_c%0d", tgt[7:0], per, j),
                  {a, b, position, busy, done}, {exp_ab, exp_pos, exp_busy, exp_done});
        end
        m_pos   = (m_pos + sgn * n) & 255;
        m_phase = (m_phase + sgn * 2 * n) & 3;
        #1 check("encoder", enc_cnt, m_pos);
    endtask

    initial begin
        int seen;
        int t;
        rst_n  = 1'b0;
        load   = 1'b0;
        target = 8'd0;
        period = 16'd1;

        do_reset();
        run_move(3, 4);
        do_reset();
        run_move(8'hFE, 1);
        run_move(8'hFE, 1);
        run_move(8'h01, 0);
        run_move(8'h01, 0);

        do_reset();
        run_move(8'hFF, 2);
        run_move(8'h01, 3);

        // Retarget while a step is half done.
        do_reset();
        @(posedge clk);
        #1;
        target = 8'd5;
        period = 16'd3;
        load   = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_edges(3, "retarget_edge3");
        target = 8'd0;
        load   = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_edges(4, "retarget_edge4");
        check("retarget_pos_mid", position, 8'd2);
        check("retarget_busy_mid", busy, 1'b1);
        seen = 0;
        for (int c = 0; c < 200 && seen == 0; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("retarget_done_seen", seen, 1);
        repeat (5) @(negedge clk);
        #1;
        check("retarget_pos_end", position, 8'd0);
        check("retarget_edges", edge_cnt, 8);
        check("retarget_done_cnt", done_cnt, 1);
        check("retarget_encoder", enc_cnt, 8'd0);
        check("retarget_idle", busy, 1'b0);

        // Reset in the middle of an 8-edge run.
        do_reset();
        @(posedge clk);
        #1;
        target = 8'd4;
        period = 16'd2;
        load   = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_edges(5, "abort_edge5");
        #1 rst_n = 1'b0;
        #1;
        check("abort_outputs", {a, b, position, busy, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_pos   = 0;
        m_phase = 0;
        run_move(1, 2);

        for (int k = 0; k < 10; k++) begin
            if (k[0]) t = $urandom_range(255, 0);
            else      t = (m_pos + $urandom_range(24, 0) - 12) & 255;
            run_move(t, $urandom_range(4, 0));
        end

        check("no_double_change", dbl_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
